qpsk_dibit_serializer: RTL and testbench

Upstream feeder for the QPSK symbol mapper. Accepts bytes over a valid/ready stream, splits each byte into four 2-bit dibits, and presents one dibit on a symbol strobe every `SYM_DIV` clocks. It tracks packet boundaries, flags mid-packet starvation, and can optionally whiten the bit stream with a per-packet-reseeded LFSR.

---
 rtl/qpsk_dibit_serializer.sv | 113 +++++++++++
 tb/tb_qpsk_dibit_serializer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qpsk_dibit_serializer.sv
// qpsk_dibit_serializer: splits a valid/ready byte stream into LSB-first dibits, one per SYM_DIV-clock strobe.
//   Optional feature macro: QPSK_SER_SCRAMBLE_EN (x^7+x^4+1 whitening, reseeded at each packet start).
//   clk, rst                      : single clock, synchronous active-high reset
//   s_data, s_valid, s_last       : input byte stream; s_ready accepts on s_valid && s_ready
//   sym_din, sym_valid, sym_last  : registered dibit, one-cycle strobe, end-of-packet marker
//   underrun                      : sticky flag, a strobe found no byte while inside a packet
module qpsk_dibit_serializer #(
    parameter int         SYM_DIV    = 4,
    parameter logic [6:0] SCRAM_SEED = 7'h7F
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [1:0] sym_din,
    output logic       sym_valid,
    output logic       sym_last,
    output logic       underrun
);
    localparam int            CW        = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(SYM_DIV - 1);
    localparam logic [0:0]    ST_EMPTY  = 1'b0;
    localparam logic [0:0]    ST_LOADED = 1'b1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [0:0]    state_q, state_d;
    logic [7:0]    hold_q, hold_d;
    logic [1:0]    idx_q, idx_d;
    logic          hold_last_q, hold_last_d;
    logic          in_pkt_q, in_pkt_d;
    logic [1:0]    sym_din_q, sym_din_d;
    logic          sym_valid_q, sym_valid_d;
    logic          sym_last_q, sym_last_d;
    logic          underrun_q, underrun_d;
    logic          strobe, emit, last_dibit, pkt_end, accept;
    logic [1:0]    dibit, dibit_out;

    assign strobe     = cnt_q == CNT_MAX;
    assign emit       = (state_q == ST_LOADED) && strobe;
    assign last_dibit = emit && (idx_q == 2'd3);
    assign pkt_end    = last_dibit && hold_last_q;
    // The slot that drains the held byte also takes the next one, so streaming has no gap slot.
    assign s_ready    = !rst && ((state_q == ST_EMPTY) || last_dibit);
    assign accept     = s_valid && s_ready;
    assign dibit      = hold_q[{idx_q, 1'b0} +: 2];

`ifdef QPSK_SER_SCRAMBLE_EN
    logic [6:0] lfsr_q, lfsr_d, lfsr_mid, lfsr_adv;
    logic       fb0, fb1;

    always_comb begin
        fb0       = lfsr_q[6] ^ lfsr_q[3];
        lfsr_mid  = {lfsr_q[5:0], fb0};
        fb1       = lfsr_mid[6] ^ lfsr_mid[3];
        lfsr_adv  = {lfsr_mid[5:0], fb1};
        dibit_out = dibit ^ {fb1, fb0};
        // A first byte may be accepted on the very strobe that closes the previous packet.
        lfsr_d    = (accept && !(in_pkt_q && !pkt_end)) ? SCRAM_SEED : (emit ? lfsr_adv : lfsr_q);
    end

    always_ff @(posedge clk) begin
        lfsr_q <= rst ? SCRAM_SEED : lfsr_d;
    end
`else
    assign dibit_out = dibit;
`endif

    always_comb begin
        cnt_d       = strobe ? '0 : cnt_q + 1'b1;
        state_d     = accept ? ST_LOADED : (last_dibit ? ST_EMPTY : state_q);
        idx_d       = accept ? 2'd0 : (emit ? idx_q + 2'd1 : idx_q);
        hold_d      = accept ? s_data : hold_q;
        hold_last_d = accept ? s_last : hold_last_q;
        in_pkt_d    = (accept && !s_last) ? 1'b1 : (pkt_end ? 1'b0 : in_pkt_q);
        sym_din_d   = emit ? dibit_out : sym_din_q;
        sym_valid_d = emit;
        sym_last_d  = pkt_end;
        underrun_d  = underrun_q || (strobe && (state_q == ST_EMPTY) && in_pkt_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            state_q     <= ST_EMPTY;
            hold_q      <= 8'h00;
            idx_q       <= 2'd0;
            hold_last_q <= 1'b0;
            in_pkt_q    <= 1'b0;
            sym_din_q   <= 2'b00;
            sym_valid_q <= 1'b0;
            sym_last_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            hold_q      <= hold_d;
            idx_q       <= idx_d;
            hold_last_q <= hold_last_d;
            in_pkt_q    <= in_pkt_d;
            sym_din_q   <= sym_din_d;
            sym_valid_q <= sym_valid_d;
            sym_last_q  <= sym_last_d;
            underrun_q  <= underrun_d;
        end
    end

    assign sym_din   = sym_din_q;
    assign sym_valid = sym_valid_q;
    assign sym_last  = sym_last_q;
    assign underrun  = underrun_q;
endmodule

// File: tb/tb_qpsk_dibit_serializer.sv
// tb_qpsk_dibit_serializer: directed stimulus against a dibit-queue model, plus literal stream checks.
module tb_qpsk_dibit_serializer;
    localparam int         D    = 3;
    localparam logic [6:0] SEED = 7'h7F;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       s_ready;
    logic [1:0] sym_din;
    logic       sym_valid, sym_last, underrun;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    qpsk_dibit_serializer #(.SYM_DIV(D), .SCRAM_SEED(SEED)) u_dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .sym_din(sym_din), .sym_valid(sym_valid), .sym_last(sym_last),
        .underrun(underrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a queue of pending dibits {last, dibit}; a strobe falls on every D-th cycle after reset.
    logic [2:0] mq[$];
    logic [1:0] got[$];
    int         lasts = 0;
    int         t = 0;
    logic       model_ok = 1'b0;
    logic       open_m = 1'b0, und_m = 1'b0, val_m = 1'b0, last_m = 1'b0, pkt_first = 1'b1;
    logic [1:0] din_m = 2'b00;
    logic [6:0] lfsr_m = SEED;
    logic       stb_m, rdy_m;
    logic [2:0] e_m;

    function automatic void push_byte(input logic [7:0] b, input logic l);
        logic [1:0] d;
        logic       fb;
        if (pkt_first) lfsr_m = SEED;
        for (int k = 0; k < 4; k++) begin
            d = b[2*k +: 2];
`ifdef QPSK_SER_SCRAMBLE_EN
            for (int j = 0; j < 2; j++) begin
                fb     = lfsr_m[6] ^ lfsr_m[3];
                d[j]   = d[j] ^ fb;
                lfsr_m = {lfsr_m[5:0], fb};
            end
`else
            fb = 1'b0;
            d  = d ^ {fb, fb};
`endif
            mq.push_back({l && (k == 3), d});
        end
        pkt_first = l;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            check("s_ready_in_reset", s_ready, 1'b0);
            mq.delete();
            t = 0; open_m = 0; und_m = 0; din_m = 0; val_m = 0; last_m = 0; pkt_first = 1;
            model_ok = 1'b1;
        end else if (model_ok) begin
            stb_m = (t % D) == D - 1;
            rdy_m = (mq.size() == 0) || (stb_m && mq.size() == 1);
            check("sym_valid", sym_valid, val_m);
            check("sym_din", sym_din, din_m);
            check("sym_last", sym_last, last_m);
            check("underrun", underrun, und_m);
            check("s_ready", s_ready, rdy_m);
            if (sym_valid) begin
                got.push_back(sym_din);
                if (sym_last) lasts++;
            end
            val_m = 1'b0;
            last_m = 1'b0;
            if (stb_m) begin
                if (mq.size() > 0) begin
                    e_m = mq.pop_front();
                    val_m = 1'b1; din_m = e_m[1:0]; last_m = e_m[2];
                    if (e_m[2]) open_m = 1'b0;
                end else if (open_m) begin
                    und_m = 1'b1;
                end
            end
            if (s_valid && rdy_m) begin
                push_byte(s_data, s_last);
                if (!s_last) open_m = 1'b1;
            end
            t++;
        end
    end

    task automatic send(input logic [7:0] b, input logic l);
        logic acc;
        int   n;
        n = 0;
        s_valid = 1'b1; s_data = b; s_last = l;
        do begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) begin
            compared++; mismatched++;
            $display("FAIL accept_timeout: byte %0h not accepted after %0d cycles", b, n);
        end
        s_valid = 1'b0; s_data = 8'($urandom); s_last = 1'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_got(input int n, input int budget);
        int k;
        k = 0;
        while (got.size() < n && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (got.size() < n) begin
            compared++; mismatched++;
            $display("FAIL wait_got: have %0d dibits, required %0d", got.size(), n);
        end
    endtask

    task automatic expect_stream(input string name, input logic [15:0] exp, input int n);
        check({name, "_count"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++) check(name, got[i], exp[2*i +: 2]);
        got.delete();
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
    endtask

    logic [7:0] sent[$];
    int         gap;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_s_ready", s_ready, 1'b1);
        check("reset_sym_valid", sym_valid, 1'b0);
        check("reset_sym_din", sym_din, 2'b00);
        check("reset_sym_last", sym_last, 1'b0);
        check("reset_underrun", underrun, 1'b0);
        @(posedge clk);
        #1;
`ifndef QPSK_SER_SCRAMBLE_EN
        // 0xB4 -> 00, 01, 11, 10
        lasts = 0;
        send(8'hB4, 1'b1);
        wait_got(4, 100);
        idle(2 * D);
        expect_stream("b4_order", {8'h00, 2'b10, 2'b11, 2'b01, 2'b00}, 4);
        check("b4_last_count", lasts, 1);
        check("b4_underrun", underrun, 1'b0);
        // 0x1B, 0xE4 back to back -> 11,10,01,00, 00,01,10,11
        lasts = 0;
        send(8'h1B, 1'b0);
        send(8'hE4, 1'b1);
        wait_got(8, 100);
        idle(2 * D);
        expect_stream("b2b_order", {2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11}, 8);
        check("b2b_last_count", lasts, 1);
        check("b2b_underrun", underrun, 1'b0);
        // Starvation inside a packet, then the packet completes
        send(8'h00, 1'b0);
        wait_got(4, 100);
        idle(20);
        check("starve_underrun", underrun, 1'b1);
        expect_stream("starve_zeros", 16'h0000, 4);
        send(8'hFF, 1'b1);
        wait_got(4, 100);
        idle(2 * D);
        expect_stream("starve_ff", 16'h00FF, 4);
        check("starve_sticky", underrun, 1'b1);
        pulse_rst();
        @(negedge clk);
        check("underrun_cleared", underrun, 1'b0);
        @(posedge clk);
        #1;
`else
        // Seed 7F on an all-zero byte: keystream bits 0,0,0,0,1,1,1,0
        send(8'h00, 1'b1);
        wait_got(4, 100);
        idle(2 * D);
        expect_stream("scram_pkt1", {8'h00, 2'b01, 2'b11, 2'b00, 2'b00}, 4);
        send(8'h00, 1'b1);
        wait_got(4, 100);
        idle(2 * D);
        expect_stream("scram_pkt2", {8'h00, 2'b01, 2'b11, 2'b00, 2'b00}, 4);
`endif
        // Reset after two dibits of a packet byte
        got.delete();
        send(8'hB4, 1'b0);
        wait_got(2, 100);
        pulse_rst();
        @(negedge clk);
        check("post_rst_ready", s_ready, 1'b1);
        check("post_rst_valid", sym_valid, 1'b0);
        @(posedge clk);
        #1;
        idle(6 * D);
        check("rst_dibit_count", got.size(), 2);
        check("rst_underrun", underrun, 1'b0);
        got.delete();
        // Random source stalls: 8 packets of 32 bytes
        lasts = 0;
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 32; i++) begin
                sent.push_back(8'($urandom));
                send(sent[sent.size() - 1], i == 31);
                gap = $urandom_range(0, 3);
                idle(gap);
            end
            gap = $urandom_range(0, 10);
            idle(gap);
        end
        wait_got(1024, 400);
        idle(2 * D);
        check("rand_dibit_count", got.size(), 1024);
        check("rand_last_count", lasts, 8);
        check("rand_underrun", underrun, 1'b0);
`ifndef QPSK_SER_SCRAMBLE_EN
        for (int i = 0; i < 256 && 4 * i + 3 < got.size(); i++)
            check("rand_reassembly", {got[4*i+3], got[4*i+2], got[4*i+1], got[4*i]}, sent[i]);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
